// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX operand resolution with EX/MEM/WB bypass, load-use stall and pipeline register
module id_ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_uses_rs1,
    input  logic              in_uses_rs2,
    input  logic              in_wb_en,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [4:0]        rf_rs1,
    output logic [4:0]        rf_rs2,
    input  logic [XLEN-1:0]   rf_rd1,
    input  logic [XLEN-1:0]   rf_rd2,
    input  logic              ex_valid,
    input  logic              ex_wb_en,
    input  logic              ex_is_load,
    input  logic [4:0]        ex_rd,
    input  logic [XLEN-1:0]   ex_result,
    input  logic              mem_valid,
    input  logic              mem_wb_en,
    input  logic [4:0]        mem_rd,
    input  logic [XLEN-1:0]   mem_result,
    input  logic              wb_wenable,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_wdata,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_rs1_val,
    output logic [XLEN-1:0]   out_rs2_val,
    output logic [4:0]        out_rd,
    output logic              out_wb_en,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [31:0]       stall_cycles
);
    logic              ex_fwd, mem_fwd, hazard, advance, fire;
    logic [XLEN-1:0]   rs1_val, rs2_val;
    logic [31:0]       stall_d, stall_q;
    logic              valid_q, wb_en_q;
    logic [XLEN-1:0]   pc_q, imm_q, rs1_q, rs2_q;
    logic [4:0]        rd_q;
    logic [CTRL_W-1:0] ctrl_q;

    assign rf_rs1  = in_rs1;
    assign rf_rs2  = in_rs2;
    // A load in EX has no data yet; it is covered by the stall, not by bypass
    assign ex_fwd  = ex_valid && ex_wb_en && !ex_is_load;
    assign mem_fwd = mem_valid && mem_wb_en;
    assign rs1_val = in_rs1 == 5'd0 ? '0 :
                     ex_fwd && ex_rd == in_rs1 ? ex_result :
                     mem_fwd && mem_rd == in_rs1 ? mem_result :
                     wb_wenable && wb_rd == in_rs1 ? wb_wdata : rf_rd1;
    assign rs2_val = in_rs2 == 5'd0 ? '0 :
                     ex_fwd && ex_rd == in_rs2 ? ex_result :
                     mem_fwd && mem_rd == in_rs2 ? mem_result :
                     wb_wenable && wb_rd == in_rs2 ? wb_wdata : rf_rd2;
    assign hazard  = ex_valid && ex_is_load && ex_wb_en && ex_rd != 5'd0 &&
                     ((in_uses_rs1 && in_rs1 == ex_rd) || (in_uses_rs2 && in_rs2 == ex_rd));
    assign advance  = !valid_q || out_ready;
    assign in_ready = rst_n && advance && !hazard && !flush;
    assign fire     = in_valid && in_ready;
    assign stall_d  = (in_valid && hazard && !flush && stall_q != 32'hFFFF_FFFF) ? stall_q + 32'd1 : stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            wb_en_q <= 1'b0;
            pc_q    <= '0;
            imm_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
            valid_q <= !flush && (fire || (!advance && valid_q));
            if (fire) begin
                wb_en_q <= in_wb_en;
                pc_q    <= in_pc;
                imm_q   <= in_imm;
                rs1_q   <= rs1_val;
                rs2_q   <= rs2_val;
                rd_q    <= in_rd;
                ctrl_q  <= in_ctrl;
            end
        end
    end

    assign out_valid    = valid_q;
    assign out_wb_en    = wb_en_q;
    assign out_pc       = pc_q;
    assign out_imm      = imm_q;
    assign out_rs1_val  = rs1_q;
    assign out_rs2_val  = rs2_q;
    assign out_rd       = rd_q;
    assign out_ctrl     = ctrl_q;
    assign stall_cycles = stall_q;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: table vectors, corner sequences and random run against a reference model
module tb_id_ex_operand_stage;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_uses_rs1, in_uses_rs2, in_wb_en;
    logic [31:0] in_pc, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd, rf_rs1, rf_rs2;
    logic [15:0] in_ctrl, out_ctrl;
    logic [31:0] rf_rd1, rf_rd2;
    logic        ex_valid, ex_wb_en, ex_is_load;
    logic [4:0]  ex_rd, mem_rd, wb_rd, out_rd;
    logic [31:0] ex_result, mem_result, wb_wdata;
    logic        mem_valid, mem_wb_en, wb_wenable, flush, out_valid, out_ready, out_wb_en;
    logic [31:0] out_pc, out_imm, out_rs1_val, out_rs2_val, stall_cycles;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage #(.XLEN(32), .CTRL_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2), .in_wb_en(in_wb_en),
        .in_imm(in_imm), .in_ctrl(in_ctrl), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .ex_valid(ex_valid), .ex_wb_en(ex_wb_en),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
        .mem_valid(mem_valid), .mem_wb_en(mem_wb_en), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_wenable(wb_wenable), .wb_rd(wb_rd), .wb_wdata(wb_wdata), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_rd(out_rd),
        .out_wb_en(out_wb_en), .out_ctrl(out_ctrl), .stall_cycles(stall_cycles)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_valid = 0; in_pc = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_uses_rs1 = 0; in_uses_rs2 = 0; in_wb_en = 0; in_imm = 0; in_ctrl = 0;
        rf_rd1 = 32'h11112222; rf_rd2 = 32'h33334444;
        ex_valid = 0; ex_wb_en = 0; ex_is_load = 0; ex_rd = 0; ex_result = 0;
        mem_valid = 0; mem_wb_en = 0; mem_rd = 0; mem_result = 0;
        wb_wenable = 0; wb_rd = 0; wb_wdata = 0; flush = 0; out_ready = 1;
    endtask

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic        ex_v, ex_ld;
        logic [4:0]  ex_rd;
        logic [31:0] ex_res;
        logic        mem_v;
        logic [4:0]  mem_rd;
        logic [31:0] mem_res;
        logic        wb_v;
        logic [4:0]  wb_rd;
        logic [31:0] wb_dat;
        logic [31:0] exp1, exp2;
    } vec_t;
    vec_t tbl[8];

    // Reference operand: the first enabled source whose destination matches wins
    function automatic logic [31:0] ref_op(input logic [4:0] rs, input logic [31:0] rf);
        logic        en[3];
        logic [4:0]  rd[3];
        logic [31:0] val[3];
        if (rs == 0) return 0;
        en[0] = ex_valid && ex_wb_en && !ex_is_load; rd[0] = ex_rd;  val[0] = ex_result;
        en[1] = mem_valid && mem_wb_en;              rd[1] = mem_rd; val[1] = mem_result;
        en[2] = wb_wenable;                          rd[2] = wb_rd;  val[2] = wb_wdata;
        for (int k = 0; k < 3; k++) if (en[k] && rd[k] == rs) return val[k];
        return rf;
    endfunction

    logic        m_valid, m_wb_en;
    logic [31:0] m_pc, m_imm, m_rs1, m_rs2, m_stall;
    logic [4:0]  m_rd;
    logic [15:0] m_ctrl;

    initial begin
        logic [31:0] st;
        tbl[0] = '{5'd1,  5'd2, 0, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  0, 5'd0, 32'h0,   32'h11112222, 32'h33334444};
        tbl[1] = '{5'd5,  5'd6, 1, 0, 5'd5, 32'hAAAA5555, 1, 5'd5,  32'h1,  1, 5'd5, 32'h2,   32'hAAAA5555, 32'h33334444};
        tbl[2] = '{5'd5,  5'd6, 0, 0, 5'd5, 32'hAAAA5555, 1, 5'd5,  32'h1,  1, 5'd5, 32'h2,   32'h1,        32'h33334444};
        tbl[3] = '{5'd5,  5'd6, 0, 0, 5'd5, 32'hAAAA5555, 0, 5'd5,  32'h1,  1, 5'd5, 32'h2,   32'h2,        32'h33334444};
        tbl[4] = '{5'd0,  5'd0, 1, 0, 5'd0, 32'hFFFFFFFF, 1, 5'd0,  32'h5,  1, 5'd0, 32'h6,   32'h0,        32'h0};
        tbl[5] = '{5'd7,  5'd8, 1, 1, 5'd9, 32'h99,       1, 5'd8,  32'h80, 1, 5'd7, 32'h70,  32'h70,       32'h80};
        tbl[6] = '{5'd3,  5'd3, 1, 0, 5'd3, 32'h3333,     0, 5'd0,  32'h0,  0, 5'd0, 32'h0,   32'h3333,     32'h3333};
        tbl[7] = '{5'd31, 5'd4, 0, 0, 5'd0, 32'h0,        1, 5'd31, 32'h31, 1, 5'd4, 32'h4444, 32'h31,      32'h4444};

        rst_n = 0;
        set_idle();
        in_valid = 1;
        #1;
        chk("reset_in_ready", in_ready, 0);
        tick(); tick();
        chk("reset_valid", out_valid, 0);
        chk("reset_pc", out_pc, 0);
        chk("reset_stall", stall_cycles, 0);
        rst_n = 1;
        set_idle();

        foreach (tbl[i]) begin
            in_valid = 1; in_uses_rs1 = 1; in_uses_rs2 = 1; in_pc = 32'(i);
            in_rs1 = tbl[i].rs1; in_rs2 = tbl[i].rs2;
            ex_valid = tbl[i].ex_v; ex_wb_en = tbl[i].ex_v; ex_is_load = tbl[i].ex_ld;
            ex_rd = tbl[i].ex_rd; ex_result = tbl[i].ex_res;
            mem_valid = tbl[i].mem_v; mem_wb_en = tbl[i].mem_v; mem_rd = tbl[i].mem_rd; mem_result = tbl[i].mem_res;
            wb_wenable = tbl[i].wb_v; wb_rd = tbl[i].wb_rd; wb_wdata = tbl[i].wb_dat;
            tick();
            chk($sformatf("tbl%0d_valid", i), out_valid, 1);
            chk($sformatf("tbl%0d_pc", i), out_pc, 32'(i));
            chk($sformatf("tbl%0d_rs1", i), out_rs1_val, tbl[i].exp1);
            chk($sformatf("tbl%0d_rs2", i), out_rs2_val, tbl[i].exp2);
        end

        set_idle();
        in_valid = 1; in_pc = 32'h40; in_rs2 = 10; in_uses_rs2 = 1;
        ex_valid = 1; ex_wb_en = 1; ex_is_load = 1; ex_rd = 10;
        #1;
        chk("lu_in_ready", in_ready, 0);
        tick();
        chk("lu_bubble", out_valid, 0);
        chk("lu_stall", stall_cycles, 1);
        ex_valid = 0; mem_valid = 1; mem_wb_en = 1; mem_rd = 10; mem_result = 32'hDEADBEEF;
        #1;
        chk("lu2_in_ready", in_ready, 1);
        tick();
        chk("lu2_valid", out_valid, 1);
        chk("lu2_rs2", out_rs2_val, 32'hDEADBEEF);
        set_idle();
        in_valid = 1; in_pc = 32'h44; in_rs2 = 10; in_uses_rs2 = 0;
        ex_valid = 1; ex_wb_en = 1; ex_is_load = 1; ex_rd = 10;
        #1;
        chk("nouse_in_ready", in_ready, 1);
        tick();
        chk("nouse_pc", out_pc, 32'h44);
        chk("nouse_rs2", out_rs2_val, 32'h33334444);
        chk("nouse_stall", stall_cycles, 1);

        set_idle();
        in_valid = 1; in_pc = 100; in_rs1 = 1; in_uses_rs1 = 1; rf_rd1 = 32'h111;
        tick();
        chk("ds_first_pc", out_pc, 100);
        out_ready = 0; in_pc = 200;
        for (int c = 0; c < 3; c++) begin
            ex_valid = 1; ex_wb_en = 1; ex_rd = 1; ex_result = $urandom;
            #1;
            chk("ds_in_ready", in_ready, 0);
            tick();
            chk("ds_valid", out_valid, 1);
            chk("ds_pc", out_pc, 100);
            chk("ds_rs1", out_rs1_val, 32'h111);
        end
        out_ready = 1; ex_valid = 0;
        #1;
        chk("ds_release_ready", in_ready, 1);
        tick();
        chk("ds_next_pc", out_pc, 200);

        out_ready = 0; in_pc = 300; flush = 1;
        #1;
        chk("fl_in_ready", in_ready, 0);
        tick();
        chk("fl_valid", out_valid, 0);
        flush = 0; in_valid = 0; out_ready = 1;
        tick();
        chk("fl_dropped", out_valid, 0);

        set_idle();
        in_valid = 1; in_pc = 400;
        tick();
        out_ready = 0; in_pc = 404; in_rs1 = 7; in_uses_rs1 = 1;
        ex_valid = 1; ex_wb_en = 1; ex_is_load = 1; ex_rd = 7;
        tick();
        chk("hz_stalled_count", stall_cycles, 2);
        chk("hz_stalled_pc", out_pc, 400);
        rst_n = 0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_rs1", out_rs1_val, 0);
        chk("rst_ctrl", 32'(out_ctrl), 0);
        chk("rst_stall", stall_cycles, 0);
        rst_n = 1;
        set_idle();

        m_valid = 0; m_wb_en = 0; m_pc = 0; m_imm = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0; m_stall = 0;
        for (int c = 0; c < 2000; c++) begin
            logic hz, adv, rdy;
            in_valid = $urandom_range(3) != 0; in_pc = $urandom; in_imm = $urandom; in_ctrl = 16'($urandom);
            in_rs1 = 5'($urandom_range(3)); in_rs2 = 5'($urandom_range(3)); in_rd = 5'($urandom);
            in_uses_rs1 = 1'($urandom); in_uses_rs2 = 1'($urandom); in_wb_en = 1'($urandom);
            rf_rd1 = $urandom; rf_rd2 = $urandom;
            ex_valid = 1'($urandom); ex_wb_en = 1'($urandom); ex_is_load = 1'($urandom);
            ex_rd = 5'($urandom_range(3)); ex_result = $urandom;
            mem_valid = 1'($urandom); mem_wb_en = 1'($urandom); mem_rd = 5'($urandom_range(3)); mem_result = $urandom;
            wb_wenable = 1'($urandom); wb_rd = 5'($urandom_range(3)); wb_wdata = $urandom;
            flush = $urandom_range(9) == 0; out_ready = $urandom_range(3) != 0;
            #1;
            hz = ex_valid && ex_is_load && ex_wb_en && ex_rd != 0 &&
                 ((in_uses_rs1 && in_rs1 == ex_rd) || (in_uses_rs2 && in_rs2 == ex_rd));
            adv = !m_valid || out_ready;
            rdy = adv && !hz && !flush;
            chk("rnd_in_ready", in_ready, rdy);
            st = (in_valid && hz && !flush && m_stall != 32'hFFFF_FFFF) ? m_stall + 1 : m_stall;
            if (flush) m_valid = 0;
            else if (in_valid && rdy) begin
                m_valid = 1; m_pc = in_pc; m_imm = in_imm; m_rd = in_rd; m_wb_en = in_wb_en; m_ctrl = in_ctrl;
                m_rs1 = ref_op(in_rs1, rf_rd1); m_rs2 = ref_op(in_rs2, rf_rd2);
            end else if (adv) m_valid = 0;
            m_stall = st;
            tick();
            chk("rnd_valid", out_valid, m_valid);
            chk("rnd_stall", stall_cycles, m_stall);
            if (m_valid) begin
                chk("rnd_pc", out_pc, m_pc);
                chk("rnd_imm", out_imm, m_imm);
                chk("rnd_rs1", out_rs1_val, m_rs1);
                chk("rnd_rs2", out_rs2_val, m_rs2);
                chk("rnd_rd", 32'(out_rd), 32'(m_rd));
                chk("rnd_wb_en", 32'(out_wb_en), 32'(m_wb_en));
                chk("rnd_ctrl", 32'(out_ctrl), 32'(m_ctrl));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
